// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode encoding, transmitter FSM states,
// payload-width limits and the parity helper.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int BIT_CNT_W     = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  function automatic logic parity_bit(input logic [1:0] mode, input logic data_xor);
    case (mode)
      PAR_ODD:  parity_bit = ~data_xor;
      PAR_MARK: parity_bit = 1'b1;
      default:  parity_bit = data_xor;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Valid/ready word handshake between the host byte source and the UART transmitter.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;

  modport master (output tx_valid, output tx_data, input  tx_ready);
  modport slave  (input  tx_valid, input  tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_frame_baud_tick.sv
// Bit-time down-counter: loads (clocks per bit - 1), flags bit_end when it reaches 0.
// Shared with the matching receiver.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] load_val_i,
  output logic             bit_end_o
);

  logic [DIV_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - DIV_W'(1);
    end
  end

  assign bit_end_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start, DATA_BITS payload LSB first, optional parity, 1-2 stops.
// Define UART_TX_HOLD_EN to add a one-word holding register for back-to-back frames.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DIV_W-1:0]      baud_div,
  input  logic [1:0]            parity_mode,
  input  logic                  two_stop,
  uart_tx_frame_if.slave        s_if,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_width
    $error("uart_tx_frame: DATA_BITS out of range");
  end

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic [DIV_W-1:0]     div_m1;
    logic                 par_en;
    logic                 par_bit;
    logic                 two_stop;
  } word_t;

  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);

  tx_state_e            state_q;
  logic                 tx_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DIV_W-1:0]     div_m1_q;
  logic                 par_en_q;
  logic                 par_q;
  logic                 two_stop_q;

  word_t in_w;
  word_t start_w;
  logic  accept;
  logic  start_now;
  logic  bit_end;
  logic  frame_end;
  logic  tick_load;
  logic  [DIV_W-1:0] tick_val;

  // Everything a frame needs is captured with the word, so later input changes are ignored.
  always_comb begin
    in_w          = '0;
    in_w.data     = s_if.tx_data;
    in_w.div_m1   = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
    in_w.par_en   = (parity_mode != PAR_NONE);
    in_w.par_bit  = parity_bit(parity_mode, ^s_if.tx_data);
    in_w.two_stop = two_stop;
  end

  assign accept    = s_if.tx_valid && s_if.tx_ready;
  assign frame_end = (state_q == STOP) && bit_end &&
                     (!two_stop_q || (bit_cnt_q == BIT_CNT_W'(1)));

`ifdef UART_TX_HOLD_EN
  word_t hold_q;
  logic  hold_full_q;
  logic  take_in;

  assign s_if.tx_ready = !hold_full_q;
  // A word arriving exactly at frame end with an empty hold starts immediately instead.
  assign take_in   = accept && (state_q != IDLE) && !(frame_end && !hold_full_q);
  assign start_now = ((state_q == IDLE) && accept) ||
                     (frame_end && (hold_full_q || accept));
  assign start_w   = (frame_end && hold_full_q) ? hold_q : in_w;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_full_q <= 1'b0;
    end else if (take_in) begin
      hold_full_q <= 1'b1;
    end else if (frame_end && hold_full_q) begin
      hold_full_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (take_in) begin
      hold_q <= in_w;
    end
  end
`else
  assign s_if.tx_ready = (state_q == IDLE);
  assign start_now     = (state_q == IDLE) && accept;
  assign start_w       = in_w;
`endif

  assign tick_load = start_now || (bit_end && !frame_end);
  assign tick_val  = start_now ? start_w.div_m1 : div_m1_q;

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (tick_load),
    .en_i       (state_q != IDLE),
    .load_val_i (tick_val),
    .bit_end_o  (bit_end)
  );

  always_ff @(posedge clk) begin
    if (start_now) begin
      shift_q    <= start_w.data;
      div_m1_q   <= start_w.div_m1;
      par_en_q   <= start_w.par_en;
      par_q      <= start_w.par_bit;
      two_stop_q <= start_w.two_stop;
    end else if ((state_q == DATA) && bit_end) begin
      shift_q <= shift_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      bit_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_now) begin
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state_q   <= DATA;
            tx_q      <= shift_q[0];
            bit_cnt_q <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_q <= '0;
              if (par_en_q) begin
                state_q <= PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
              tx_q      <= shift_q[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_q   <= STOP;
            tx_q      <= 1'b1;
            bit_cnt_q <= '0;
          end
        end
        STOP: begin
          if (frame_end) begin
            bit_cnt_q <= '0;
            if (start_now) begin
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else if (bit_end) begin
            bit_cnt_q <= BIT_CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx      = tx_q;
  assign busy    = (state_q != IDLE);
  assign tx_done = frame_end;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame (8 data bits): table vectors, random frames
// against a bit-list frame model, reset abort and back-to-back sequences.
module tb_uart_tx_frame;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] baud_div = 16'd4;
  logic [1:0]  parity_mode = 2'b00;
  logic        two_stop = 1'b0;
  wire         tx;
  wire         busy;
  wire         tx_done;

  uart_tx_frame_if #(.DATA_BITS(8)) bus ();

  uart_tx_frame #(.DATA_BITS(8), .DIV_W(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .s_if        (bus),
    .tx          (tx),
    .busy        (busy),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit exp_q[$];
  bit obs_q[$];

  typedef struct {
    logic [7:0] data;
    int         div;
    logic [1:0] pm;
    logic       two;
    int         len;
    logic       par;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Serial line as a list of bit values, each stretched to the bit time.
  function automatic void model_frame(input logic [7:0] d, input int div,
                                      input logic [1:0] pm, input logic two);
    int eff;
    bit b[$];
    eff = (div == 0) ? 1 : div;
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(d[i]);
    if (pm != 2'b00) b.push_back((pm == 2'b11) ? 1'b1 : ((pm == 2'b10) ? ~(^d) : ^d));
    b.push_back(1'b1);
    if (two) b.push_back(1'b1);
    foreach (b[i]) repeat (eff) exp_q.push_back(b[i]);
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_stream(input string nm, output int nbusy);
    int len;
    len = exp_q.size();
    nbusy = 0;
    obs_q.delete();
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      obs_q.push_back(tx);
      chk({nm, "_tx"}, {31'd0, tx}, {31'd0, exp_q[k]});
      chk({nm, "_done"}, {31'd0, tx_done}, {31'd0, (k == len - 1)});
      if (busy) nbusy++;
    end
    chk({nm, "_busylen"}, nbusy, len);
    @(negedge clk);
    chk({nm, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_idle_tx"}, {31'd0, tx}, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] d, input int div, input logic [1:0] pm,
                            input logic two, input int div_after, input string nm,
                            output int nbusy);
    exp_q.delete();
    model_frame(d, div, pm, two);
    wait_ready();
    baud_div     = 16'(div);
    parity_mode  = pm;
    two_stop     = two;
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = ~d;
    baud_div     = 16'(div_after);
    parity_mode  = ~pm;
    two_stop     = ~two;
    check_stream(nm, nbusy);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;

    vecs[0] = '{8'hA5, 4, 2'b01, 1'b0, 44, 1'b0};
    vecs[1] = '{8'h07, 4, 2'b10, 1'b0, 44, 1'b0};
    vecs[2] = '{8'h07, 4, 2'b11, 1'b0, 44, 1'b1};
    vecs[3] = '{8'h07, 4, 2'b00, 1'b0, 40, 1'b0};
    vecs[4] = '{8'hFF, 0, 2'b01, 1'b1, 12, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, bus.tx_ready}, 32'd1);
    chk("rst_done", {31'd0, tx_done}, 32'd0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      send_frame(vecs[i].data, vecs[i].div, vecs[i].pm, vecs[i].two, 7, $sformatf("vec%0d", i), nb);
      chk($sformatf("vec%0d_len", i), nb, vecs[i].len);
      if (vecs[i].pm != 2'b00)
        chk($sformatf("vec%0d_par", i), {31'd0, obs_q[9 * ((vecs[i].div == 0) ? 1 : vecs[i].div)]},
            {31'd0, vecs[i].par});
    end

    send_frame(8'h3C, 4, 2'b01, 1'b0, 8, "baudchg_a", nb);
    chk("baudchg_a_len", nb, 44);
    send_frame(8'hC3, 8, 2'b01, 1'b0, 8, "baudchg_b", nb);
    chk("baudchg_b_len", nb, 88);

    // Abort mid-payload: line must return high without waiting for a clock.
    wait_ready();
    baud_div = 16'd4; parity_mode = 2'b01; two_stop = 1'b0;
    bus.tx_data = 8'h5A; bus.tx_valid = 1'b1;
    @(posedge clk); #1 bus.tx_valid = 1'b0;
    repeat (12) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_tx", {31'd0, tx}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ready", {31'd0, bus.tx_ready}, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    send_frame(8'h81, 4, 2'b01, 1'b0, 4, "after_abort", nb);

    for (int r = 0; r < 20; r++) begin
      send_frame(8'($urandom), $urandom_range(0, 5), 2'($urandom), 1'($urandom),
                 $urandom_range(0, 9), $sformatf("rnd%0d", r), nb);
    end

`ifdef UART_TX_HOLD_EN
    exp_q.delete();
    model_frame(8'h11, 2, 2'b01, 1'b0);
    model_frame(8'h22, 2, 2'b01, 1'b0);
    wait_ready();
    baud_div = 16'd2; parity_mode = 2'b01; two_stop = 1'b0;
    bus.tx_data = 8'h11; bus.tx_valid = 1'b1;
    @(posedge clk); #1 bus.tx_data = 8'h22;
    for (int k = 0; k < 44; k++) begin
      @(negedge clk);
      if (k == 1) bus.tx_valid = 1'b0;
      chk("b2b_tx", {31'd0, tx}, {31'd0, exp_q[k]});
      chk("b2b_busy", {31'd0, busy}, 32'd1);
      chk("b2b_done", {31'd0, tx_done}, {31'd0, (k == 21 || k == 43)});
    end
    @(negedge clk);
    chk("b2b_end_busy", {31'd0, busy}, 32'd0);
`else
    // Second word waits for IDLE: one idle clock separates the frames.
    exp_q.delete();
    model_frame(8'h5A, 2, 2'b00, 1'b0);
    exp_q.push_back(1'b1);
    model_frame(8'h96, 2, 2'b00, 1'b0);
    wait_ready();
    baud_div = 16'd2; parity_mode = 2'b00; two_stop = 1'b0;
    bus.tx_data = 8'h5A; bus.tx_valid = 1'b1;
    @(posedge clk); #1 bus.tx_data = 8'h96;
    for (int k = 0; k < 41; k++) begin
      @(negedge clk);
      if (k == 21) bus.tx_valid = 1'b0;
      if (k == 5) chk("held_ready", {31'd0, bus.tx_ready}, 32'd0);
      chk("held_tx", {31'd0, tx}, {31'd0, exp_q[k]});
      chk("held_busy", {31'd0, busy}, {31'd0, (k != 20)});
      chk("held_done", {31'd0, tx_done}, {31'd0, (k == 19 || k == 40)});
    end
    @(negedge clk);
    chk("held_end_busy", {31'd0, busy}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
